// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
// Shared types and default sizes for the multi-port register file.
//   rf_state_e    : top-level sequencing (post-reset clear vs. normal run)
//   rf_wr_port_t  : one write port bundle {we, addr, data} at default widths
package regfile_mp_pkg;

  localparam int RF_DEF_DATA_W = 32;
  localparam int RF_DEF_ADDR_W = 5;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  typedef struct packed {
    logic                     we;
    logic [RF_DEF_ADDR_W-1:0] addr;
    logic [RF_DEF_DATA_W-1:0] data;
  } rf_wr_port_t;

endpackage

// File: rtl/regfile_dbg_arb.sv
// regfile_dbg_arb
// Arbitrates the debug port against core writeback and holds debug read data.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   run_i            : register file is out of its clear sequence
//   core_we_any_i    : at least one core write port is active this cycle
//   dbg_req_i/we_i   : debug request (held until granted) and direction
//   rd_bypass_i      : bypassed read value of the debug address
//   dbg_gnt_o        : combinational grant, one cycle per access
//   stall_o          : asks the core to suppress writes next cycle
//   dbg_rvalid_o     : one-cycle pulse after a granted debug read
//   dbg_rdata_o      : read data captured at the grant edge
module regfile_dbg_arb #(
  parameter int DATA_W       = 32,
  parameter int DBG_WAIT_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              core_we_any_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [DATA_W-1:0] rd_bypass_i,
  output logic              dbg_gnt_o,
  output logic              stall_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  localparam int CNT_W = $clog2(DBG_WAIT_MAX + 1);

  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              w_stall;
  logic              w_gnt;
  logic              w_rd_gnt;

  // Once the request has waited the full budget, stall_o both asks the core
  // to back off and forces the grant in the same cycle; a core write still
  // present that cycle keeps priority over the debug write.
  assign w_stall  = run_i && dbg_req_i && (r_wait_cnt == CNT_W'(DBG_WAIT_MAX));
  assign w_gnt    = run_i && dbg_req_i && (!core_we_any_i || w_stall);
  assign w_rd_gnt = w_gnt && !dbg_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (!run_i || !dbg_req_i || w_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != CNT_W'(DBG_WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      r_rvalid <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rdata <= rd_bypass_i;
      end
    end
  end

  assign dbg_gnt_o    = w_gnt;
  assign stall_o      = w_stall;
  assign dbg_rvalid_o = r_rvalid;
  assign dbg_rdata_o  = r_rdata;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file with prioritised writes, bypassed reads, a busy
// scoreboard, an arbitrated debug port and a post-reset sequential clear.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  : NUM_WR core write ports, higher index wins
//   raddr_i/rdata_o       : NUM_RD combinational bypassed read ports
//   sb_set_i/_addr_i      : mark a register busy at issue
//   busy_o                : per-register busy bits
//   dbg_*                 : debug access port (see regfile_dbg_arb)
//   stall_o               : asks the core to suppress writes next cycle
//   init_done_o           : clear sequence complete
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W       = RF_DEF_DATA_W,
  parameter int ADDR_W       = RF_DEF_ADDR_W,
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 2,
  parameter int ZERO_REG     = 1,
  parameter int DBG_WAIT_MAX = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_WR-1:0]              we_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  waddr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wdata_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  raddr_i,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rdata_o,
  input  logic                           sb_set_i,
  input  logic [ADDR_W-1:0]              sb_set_addr_i,
  output logic [(1<<ADDR_W)-1:0]         busy_o,
  input  logic                           dbg_req_i,
  input  logic                           dbg_we_i,
  input  logic [ADDR_W-1:0]              dbg_addr_i,
  input  logic [DATA_W-1:0]              dbg_wdata_i,
  output logic                           dbg_gnt_o,
  output logic                           dbg_rvalid_o,
  output logic [DATA_W-1:0]              dbg_rdata_o,
  output logic                           stall_o,
  output logic                           init_done_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  rf_state_e         r_state;
  rf_state_e         w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_init_done;
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_next;
  logic              w_run;
  logic              w_dbg_gnt;

  // Read lookups: indices 0..NUM_RD-1 are the core ports, index NUM_RD is
  // the debug address, so debug reads see exactly the same bypass path.
  logic [ADDR_W-1:0] w_rd_addr [NUM_RD+1];
  logic [DATA_W-1:0] w_rd_data [NUM_RD+1];

  assign w_run = (r_state == RF_RUN);

  // ---------------- clear sequencer ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RF_INIT: if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_next = RF_RUN;
      RF_RUN:  w_state_next = RF_RUN;
      default: w_state_next = RF_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RF_INIT;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_done <= (w_state_next == RF_RUN);
      if (r_state == RF_INIT) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // ---------------- storage ----------------
  // Debug write is issued first so any same-address core write overrides it;
  // core ports are walked in ascending order so the highest index lands last.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == RF_INIT) begin
        r_mem[r_clr_cnt] <= '0;
      end else begin
        if (w_dbg_gnt && dbg_we_i && !(ZERO_REG != 0 && dbg_addr_i == '0)) begin
          r_mem[dbg_addr_i] <= dbg_wdata_i;
        end
        for (int p = 0; p < NUM_WR; p++) begin
          if (we_i[p] && !(ZERO_REG != 0 && waddr_i[p] == '0)) begin
            r_mem[waddr_i[p]] <= wdata_i[p];
          end
        end
      end
    end
  end

  // ---------------- bypassed reads ----------------
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_addr
      assign w_rd_addr[gi] = raddr_i[gi];
      assign rdata_o[gi]   = w_rd_data[gi];
    end
  endgenerate
  assign w_rd_addr[NUM_RD] = dbg_addr_i;

  generate
    for (genvar gi = 0; gi <= NUM_RD; gi++) begin : g_rd
      logic [DATA_W-1:0] w_val;
      always_comb begin
        w_val = r_mem[w_rd_addr[gi]];
        for (int p = 0; p < NUM_WR; p++) begin
          if (we_i[p] && waddr_i[p] == w_rd_addr[gi]) begin
            w_val = wdata_i[p];
          end
        end
        if (!w_run || (ZERO_REG != 0 && w_rd_addr[gi] == '0)) begin
          w_val = '0;
        end
      end
      assign w_rd_data[gi] = w_val;
    end
  endgenerate

  // ---------------- scoreboard ----------------
  // Clears are applied before the set so an issue and a writeback to the
  // same register in one cycle leaves it busy.
  always_comb begin
    w_busy_next = r_busy;
    for (int p = 0; p < NUM_WR; p++) begin
      if (we_i[p]) begin
        w_busy_next[waddr_i[p]] = 1'b0;
      end
    end
    if (sb_set_i) begin
      w_busy_next[sb_set_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else if (w_run) begin
      r_busy <= w_busy_next;
    end
  end

  // ---------------- debug port ----------------
  regfile_dbg_arb #(
    .DATA_W       (DATA_W),
    .DBG_WAIT_MAX (DBG_WAIT_MAX)
  ) u_dbg_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .run_i         (w_run),
    .core_we_any_i (|we_i),
    .dbg_req_i     (dbg_req_i),
    .dbg_we_i      (dbg_we_i),
    .rd_bypass_i   (w_rd_data[NUM_RD]),
    .dbg_gnt_o     (w_dbg_gnt),
    .stall_o       (stall_o),
    .dbg_rvalid_o  (dbg_rvalid_o),
    .dbg_rdata_o   (dbg_rdata_o)
  );

  assign dbg_gnt_o   = w_dbg_gnt;
  assign busy_o      = r_busy;
  assign init_done_o = r_init_done;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Self-checking bench: a behavioural model of the register file is advanced
// once per clock and every DUT output is compared against it at the falling
// edge; directed scenarios add explicit constant expectations on top.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 32;
  localparam int WMAX   = 4;

  logic                          clk = 1'b0;
  logic                          rst_i;
  logic [NUM_WR-1:0]             we_i;
  logic [NUM_WR-1:0][ADDR_W-1:0] waddr_i;
  logic [NUM_WR-1:0][DATA_W-1:0] wdata_i;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr_i;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata_o;
  logic                          sb_set_i;
  logic [ADDR_W-1:0]             sb_set_addr_i;
  logic [DEPTH-1:0]              busy_o;
  logic                          dbg_req_i;
  logic                          dbg_we_i;
  logic [ADDR_W-1:0]             dbg_addr_i;
  logic [DATA_W-1:0]             dbg_wdata_i;
  logic                          dbg_gnt_o;
  logic                          dbg_rvalid_o;
  logic [DATA_W-1:0]             dbg_rdata_o;
  logic                          stall_o;
  logic                          init_done_o;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .ZERO_REG(1), .DBG_WAIT_MAX(WMAX)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .sb_set_i(sb_set_i),
    .sb_set_addr_i(sb_set_addr_i), .busy_o(busy_o), .dbg_req_i(dbg_req_i),
    .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .stall_o(stall_o), .init_done_o(init_done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0]  m_busy   = '0;
  int                m_init_left = DEPTH;  // cycles of clearing still to go
  int                m_wait   = 0;
  bit                m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_drdata = '0;
  bit                m_gnt    = 1'b0;

  // Value a reader sees: zero while clearing or for x0, otherwise the
  // highest-numbered port writing the address now, otherwise stored data.
  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (m_init_left != 0 || a == 0) return '0;
    for (int p = NUM_WR - 1; p >= 0; p--) begin
      if (we_i[p] && waddr_i[p] == a) return wdata_i[p];
    end
    return m_mem[a];
  endfunction

  function automatic bit m_stall_f();
    return (m_init_left == 0) && dbg_req_i && (m_wait == WMAX);
  endfunction

  function automatic bit m_gnt_f();
    return (m_init_left == 0) && dbg_req_i && (we_i == '0 || m_wait == WMAX);
  endfunction

  task automatic sample();
    @(negedge clk);
    for (int r = 0; r < NUM_RD; r++) begin
      check($sformatf("rdata%0d", r), rdata_o[r], m_read(raddr_i[r]));
    end
    check("busy", busy_o, m_busy);
    check("gnt", dbg_gnt_o, m_gnt_f());
    check("stall", stall_o, m_stall_f());
    check("rvalid", dbg_rvalid_o, m_rvalid);
    check("drdata", dbg_rdata_o, m_drdata);
    check("init_done", init_done_o, m_init_left == 0);
  endtask

  task automatic tick();
    logic [DATA_W-1:0] rd;
    bit g;
    @(posedge clk);
    if (rst_i) begin
      m_init_left = DEPTH;
      m_wait      = 0;
      m_rvalid    = 1'b0;
      m_drdata    = '0;
      m_busy      = '0;
      m_gnt       = 1'b0;
    end else if (m_init_left != 0) begin
      m_init_left--;
      m_wait   = 0;
      m_rvalid = 1'b0;
      m_gnt    = 1'b0;
      if (m_init_left == 0) begin
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      g        = m_gnt_f();
      rd       = m_read(dbg_addr_i);
      m_gnt    = g;
      m_rvalid = g && !dbg_we_i;
      if (m_rvalid) m_drdata = rd;
      if (!dbg_req_i || g) m_wait = 0;
      else if (m_wait < WMAX) m_wait++;
      // Final content of each address: highest core port, else debug.
      if (g && dbg_we_i && dbg_addr_i != 0) m_mem[dbg_addr_i] = dbg_wdata_i;
      for (int a = 1; a < DEPTH; a++) begin
        for (int p = NUM_WR - 1; p >= 0; p--) begin
          if (we_i[p] && waddr_i[p] == ADDR_W'(a)) begin
            m_mem[a] = wdata_i[p];
            break;
          end
        end
      end
      for (int a = 1; a < DEPTH; a++) begin
        if (sb_set_i && sb_set_addr_i == ADDR_W'(a)) m_busy[a] = 1'b1;
        else if (|(we_i & {waddr_i[1] == ADDR_W'(a), waddr_i[0] == ADDR_W'(a)})) m_busy[a] = 1'b0;
      end
      m_busy[0] = 1'b0;
    end
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom % 2 == 0) return ADDR_W'($urandom_range(0, 7));
    return ADDR_W'($urandom);
  endfunction

  task automatic rand_core();
    we_i = NUM_WR'($urandom);
    for (int p = 0; p < NUM_WR; p++) begin
      waddr_i[p] = rand_addr();
      wdata_i[p] = $urandom;
    end
    for (int r = 0; r < NUM_RD; r++) raddr_i[r] = rand_addr();
    sb_set_i      = ($urandom % 3) == 0;
    sb_set_addr_i = rand_addr();
  endtask

  task automatic quiet_core();
    we_i     = '0;
    sb_set_i = 1'b0;
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    dbg_req_i   = req;
    dbg_we_i    = we;
    dbg_addr_i  = a;
    dbg_wdata_i = d;
  endtask

  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    while (cnt < 100) begin
      rand_core();
      sample();
      if (init_done_o) break;
      tick();
      cnt++;
    end
    check(tag, cnt, DEPTH);
    quiet_core();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    rst_i = 1'b1;
    set_dbg(1'b0, 1'b0, '0, '0);
    repeat (3) begin
      rand_core();
      tick();
    end

    // Clear after reset, with core/debug activity that must be ignored.
    rst_i = 1'b0;
    set_dbg(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF);
    wait_init("init_len");
    set_dbg(1'b0, 1'b0, '0, '0);
    $display("txn: clear sequence finished");
    for (int a = 0; a < DEPTH; a += 2) begin
      raddr_i[0] = ADDR_W'(a);
      raddr_i[1] = ADDR_W'(a + 1);
      sample();
      check("clr_rd0", rdata_o[0], 0);
      check("clr_rd1", rdata_o[1], 0);
      tick();
    end

    // Two ports to x5 in one cycle: port 1 wins, bypass and array agree.
    we_i = 2'b11; waddr_i[0] = 5'd5; waddr_i[1] = 5'd5;
    wdata_i[0] = 32'h11; wdata_i[1] = 32'h22; raddr_i[0] = 5'd5;
    sample(); check("byp_x5", rdata_o[0], 32'h22); tick();
    quiet_core();
    sample(); check("arr_x5", rdata_o[0], 32'h22); tick();
    $display("txn: dual write x5");

    // x0 stays zero and never busy, from core and debug.
    we_i = 2'b01; waddr_i[0] = 5'd0; wdata_i[0] = 32'hDEAD;
    sb_set_i = 1'b1; sb_set_addr_i = 5'd0; raddr_i[0] = 5'd0;
    sample(); check("x0_byp", rdata_o[0], 0); tick();
    quiet_core();
    set_dbg(1'b1, 1'b1, 5'd0, 32'hDEAD);
    sample(); check("x0_dbg_gnt", dbg_gnt_o, 1); tick();
    set_dbg(1'b0, 1'b0, '0, '0);
    sample(); check("x0_rd", rdata_o[0], 0); check("x0_busy", busy_o[0], 0); tick();
    $display("txn: writes to x0");

    // Scoreboard set, clear, and set-wins.
    sb_set_i = 1'b1; sb_set_addr_i = 5'd7;
    tick(); quiet_core();
    sample(); check("busy7_set", busy_o[7], 1);
    we_i = 2'b01; waddr_i[0] = 5'd7; wdata_i[0] = 32'h77;
    tick(); quiet_core();
    sample(); check("busy7_clr", busy_o[7], 0);
    we_i = 2'b01; sb_set_i = 1'b1;
    tick(); quiet_core();
    sample(); check("busy7_setwins", busy_o[7], 1); tick();
    $display("txn: scoreboard x7");

    // Debug read of x5 against continuous core writes: forced slot.
    set_dbg(1'b1, 1'b0, 5'd5, '0);
    we_i = 2'b01; waddr_i[0] = 5'd12;
    c = 0;
    while (c < 20) begin
      wdata_i[0] = $urandom;
      sample();
      if (dbg_gnt_o) break;
      tick();
      c++;
    end
    check("dbg_wait", c, WMAX);
    check("dbg_stall", stall_o, 1);
    tick();
    set_dbg(1'b0, 1'b0, '0, '0); quiet_core();
    sample(); check("dbg_rvalid", dbg_rvalid_o, 1); check("dbg_rdata", dbg_rdata_o, 32'h22); tick();
    sample(); check("dbg_rvalid_pulse", dbg_rvalid_o, 0); tick();
    $display("txn: forced debug read x5");

    // Forced debug write to x3 colliding with a core write: core wins.
    set_dbg(1'b1, 1'b1, 5'd3, 32'hAA);
    we_i = 2'b01; waddr_i[0] = 5'd3; wdata_i[0] = 32'hBB;
    c = 0;
    while (c < 20) begin
      sample();
      if (dbg_gnt_o) break;
      tick();
      c++;
    end
    check("dbgw_wait", c, WMAX);
    tick();
    set_dbg(1'b0, 1'b0, '0, '0); quiet_core(); raddr_i[0] = 5'd3;
    sample(); check("x3_core_wins", rdata_o[0], 32'hBB); tick();
    $display("txn: debug/core collision x3");

    // Random traffic, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rand_core();
      rst_i = ($urandom % 400) == 0;
      if (!dbg_req_i && ($urandom % 4) == 0) begin
        set_dbg(1'b1, 1'($urandom), rand_addr(), $urandom);
      end
      sample();
      tick();
      if (m_gnt) dbg_req_i = 1'b0;
    end
    rst_i = 1'b0;
    set_dbg(1'b0, 1'b0, '0, '0);
    quiet_core();
    $display("txn: random traffic done");

    // Reset in the middle of clearing restarts the full sequence.
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    repeat (10) begin
      rand_core();
      sample();
      tick();
    end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    wait_init("reinit_len");
    raddr_i[0] = 5'd3;
    sample(); check("reinit_x3", rdata_o[0], 0); tick();
    $display("txn: reset during clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
